nios_system_sysid_checker: RTL and testbench



---
 rtl/nios_system_sysid_checker_pkg.sv | 24 ++
 rtl/nios_system_sysid_checker.sv | 210 +++++++++++++++++++++
 tb/tb_nios_system_sysid_checker.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_system_sysid_checker_pkg.sv
// Shared definitions for the boot-time system-ID checker: state encoding,
// sysid slave register addresses and the slave's reset-value constants.
package nios_system_sysid_checker_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      WAIT_ID,
      RD_TS,
      WAIT_TS,
      CHECK,
      DONE
   } state_t;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   localparam logic [31:0] SYSID_ID_RESET = 32'd0;
   localparam logic [31:0] SYSID_TS_RESET = 32'd1478524007;

   localparam int RETRY_W = 4;
   localparam int TIMER_W = 16;

endpackage

// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words at boot,
// compares them against expected values and retries failed attempts.
module nios_system_sysid_checker
   import nios_system_sysid_checker_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = SYSID_ID_RESET,
   parameter logic [31:0] EXPECTED_TS    = SYSID_TS_RESET,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_mismatch,
   output logic        ts_mismatch,
   output logic        timeout,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts
);

   localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   state_t               state;
   state_t               next_state;
   logic [RETRY_W-1:0]   retry_cnt;
   logic [TIMER_W-1:0]   timer;
   logic                 auto_pending;

   logic                 load_timer;
   logic                 tick_timer;
   logic                 cap_id;
   logic                 cap_ts;
   logic                 set_timeout;
   logic                 clear_all;
   logic                 retry;
   logic                 finish;
   logic                 expired;
   logic                 id_diff;
   logic                 ts_diff;
   logic                 failed;

   assign busy = (state != IDLE) && (state != DONE);
   assign done = (state == DONE);

   // A timed-out attempt never reports compare mismatches, only the timeout.
   assign id_diff = !timeout && (captured_id != EXPECTED_ID);
   assign ts_diff = !timeout && (captured_ts != EXPECTED_TS);
   assign failed  = timeout || id_diff || ts_diff;
   assign expired = (timer == TIMEOUT_LAST);

   always_comb begin
      next_state  = state;
      load_timer  = 1'b0;
      tick_timer  = 1'b0;
      cap_id      = 1'b0;
      cap_ts      = 1'b0;
      set_timeout = 1'b0;
      clear_all   = 1'b0;
      retry       = 1'b0;
      finish      = 1'b0;
      avm_read    = 1'b0;
      avm_address = ADDR_ID;
      case (state)
         IDLE: begin
            if (start || auto_pending) begin
               next_state = RD_ID;
               clear_all  = 1'b1;
               load_timer = 1'b1;
            end
         end
         RD_ID: begin
            avm_read    = 1'b1;
            avm_address = ADDR_ID;
            if (!avm_waitrequest && avm_readdatavalid) begin
               cap_id     = 1'b1;
               load_timer = 1'b1;
               next_state = RD_TS;
            end else if (expired) begin
               set_timeout = 1'b1;
               next_state  = CHECK;
            end else begin
               tick_timer = 1'b1;
               if (!avm_waitrequest) begin
                  next_state = WAIT_ID;
               end
            end
         end
         WAIT_ID: begin
            if (avm_readdatavalid) begin
               cap_id     = 1'b1;
               load_timer = 1'b1;
               next_state = RD_TS;
            end else if (expired) begin
               set_timeout = 1'b1;
               next_state  = CHECK;
            end else begin
               tick_timer = 1'b1;
            end
         end
         RD_TS: begin
            avm_read    = 1'b1;
            avm_address = ADDR_TS;
            if (!avm_waitrequest && avm_readdatavalid) begin
               cap_ts     = 1'b1;
               next_state = CHECK;
            end else if (expired) begin
               set_timeout = 1'b1;
               next_state  = CHECK;
            end else begin
               tick_timer = 1'b1;
               if (!avm_waitrequest) begin
                  next_state = WAIT_TS;
               end
            end
         end
         WAIT_TS: begin
            avm_address = ADDR_TS;
            if (avm_readdatavalid) begin
               cap_ts     = 1'b1;
               next_state = CHECK;
            end else if (expired) begin
               set_timeout = 1'b1;
               next_state  = CHECK;
            end else begin
               tick_timer = 1'b1;
            end
         end
         CHECK: begin
            if (failed && (retry_cnt < RETRY_LIMIT)) begin
               retry      = 1'b1;
               load_timer = 1'b1;
               next_state = RD_ID;
            end else begin
               finish     = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            if (start) begin
               next_state = RD_ID;
               clear_all  = 1'b1;
               load_timer = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         auto_pending <= AUTO_START;
         retry_cnt    <= '0;
         timer        <= '0;
         pass         <= 1'b0;
         id_mismatch  <= 1'b0;
         ts_mismatch  <= 1'b0;
         timeout      <= 1'b0;
         captured_id  <= '0;
         captured_ts  <= '0;
      end else begin
         state <= next_state;
         if (clear_all) begin
            auto_pending <= 1'b0;
         end
         // Saturating per-access cycle counter.
         if (load_timer) begin
            timer <= '0;
         end else if (tick_timer && (timer != '1)) begin
            timer <= timer + 16'd1;
         end
         if (cap_id) begin
            captured_id <= avm_readdata;
         end
         if (cap_ts) begin
            captured_ts <= avm_readdata;
         end
         if (set_timeout) begin
            timeout <= 1'b1;
         end
         if (clear_all || retry) begin
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
         end
         if (clear_all) begin
            retry_cnt <= '0;
         end else if (retry) begin
            retry_cnt <= retry_cnt + 4'd1;
         end
         if (finish) begin
            pass        <= !failed;
            id_mismatch <= id_diff;
            ts_mismatch <= ts_diff;
         end
      end
   end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Scoreboard bench for the sysid checker: a scripted Avalon slave drives the
// main instance, a second instance with a silent slave exercises timeouts.
module tb_nios_system_sysid_checker;

   localparam logic [31:0] GOOD_ID = 32'd0;
   localparam logic [31:0] GOOD_TS = 32'h58207C67;
   localparam logic [31:0] BAD_TS  = 32'h58207C68;

   typedef struct {
      logic        pass;
      logic        id_mm;
      logic        ts_mm;
      logic        to;
      logic [31:0] cid;
      logic [31:0] cts;
      int          lat;
      int          reads;
      int          start_cyc;
      int          reads_base;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest = 1'b0;
   logic        avm_readdatavalid = 1'b0;
   logic [31:0] avm_readdata = '0;
   logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
   logic [31:0] captured_id, captured_ts;

   logic        to_start = 1'b0;
   logic        to_zero = 1'b0;
   logic [31:0] to_data = '0;
   logic        to_address, to_read, to_busy, to_done, to_pass;
   logic        to_id_mm, to_ts_mm, to_timeout;
   logic [31:0] to_cid, to_cts;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int reads = 0;
   int to_reads = 0;

   logic        slave_en = 1'b1;
   logic [31:0] slave_id = GOOD_ID;
   logic [31:0] slave_ts = GOOD_TS;
   int          slave_wait = 0;
   int          slave_lat = 0;

   exp_t exp_q[$];
   exp_t exp_to_q[$];

   nios_system_sysid_checker #(
      .EXPECTED_ID(32'd0), .EXPECTED_TS(32'h58207C67), .MAX_RETRIES(3),
      .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)
   ) dut (
      .clock(clock), .reset(reset), .start(start),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
      .avm_readdata(avm_readdata),
      .busy(busy), .done(done), .pass(pass), .id_mismatch(id_mismatch),
      .ts_mismatch(ts_mismatch), .timeout(timeout),
      .captured_id(captured_id), .captured_ts(captured_ts)
   );

   nios_system_sysid_checker #(
      .EXPECTED_ID(32'd0), .EXPECTED_TS(32'h58207C67), .MAX_RETRIES(1),
      .TIMEOUT_CYCLES(10), .AUTO_START(1'b0)
   ) dut_to (
      .clock(clock), .reset(reset), .start(to_start),
      .avm_address(to_address), .avm_read(to_read),
      .avm_waitrequest(to_zero), .avm_readdatavalid(to_zero),
      .avm_readdata(to_data),
      .busy(to_busy), .done(to_done), .pass(to_pass), .id_mismatch(to_id_mm),
      .ts_mismatch(to_ts_mm), .timeout(to_timeout),
      .captured_id(to_cid), .captured_ts(to_cts)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mkExp(input logic p, input logic idm, input logic tsm, input logic to,
                                  input logic [31:0] cid, input logic [31:0] cts,
                                  input int lat, input int nreads);
      exp_t e;
      e.pass = p; e.id_mm = idm; e.ts_mm = tsm; e.to = to;
      e.cid = cid; e.cts = cts; e.lat = lat; e.reads = nreads;
      e.start_cyc = 0; e.reads_base = 0;
      return e;
   endfunction

   task automatic compareResult(input string tag, input exp_t e,
                                input logic a_pass, input logic a_idm, input logic a_tsm,
                                input logic a_to, input logic a_read, input logic a_busy,
                                input logic [31:0] a_cid, input logic [31:0] a_cts,
                                input int a_lat, input int a_reads);
      checkOutput({tag, ".pass"}, a_pass, e.pass);
      checkOutput({tag, ".id_mismatch"}, a_idm, e.id_mm);
      checkOutput({tag, ".ts_mismatch"}, a_tsm, e.ts_mm);
      checkOutput({tag, ".timeout"}, a_to, e.to);
      checkOutput({tag, ".captured_id"}, a_cid, e.cid);
      checkOutput({tag, ".captured_ts"}, a_cts, e.cts);
      checkOutput({tag, ".avm_read"}, a_read, 1'b0);
      checkOutput({tag, ".busy"}, a_busy, 1'b0);
      checkOutput({tag, ".done_cycle"}, a_lat, e.lat);
      checkOutput({tag, ".reads"}, a_reads, e.reads);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".avm_read"}, avm_read, 1'b0);
      checkOutput({tag, ".avm_address"}, avm_address, 1'b0);
      checkOutput({tag, ".busy"}, busy, 1'b0);
      checkOutput({tag, ".done"}, done, 1'b0);
      checkOutput({tag, ".pass"}, pass, 1'b0);
      checkOutput({tag, ".id_mismatch"}, id_mismatch, 1'b0);
      checkOutput({tag, ".ts_mismatch"}, ts_mismatch, 1'b0);
      checkOutput({tag, ".timeout"}, timeout, 1'b0);
      checkOutput({tag, ".captured_id"}, captured_id, 32'd0);
      checkOutput({tag, ".captured_ts"}, captured_ts, 32'd0);
   endtask

   // Configures the slave, records the expected result and pulses start.
   task automatic applyStimulus(input logic [31:0] sid, input logic [31:0] sts,
                                input int w, input int l, input exp_t e);
      @(negedge clock);
      slave_id   = sid;
      slave_ts   = sts;
      slave_wait = w;
      slave_lat  = l;
      e.start_cyc  = cyc;
      e.reads_base = reads;
      exp_q.push_back(e);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic waitIdle(input string name, input int limit);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp_to_q.size() != 0) && n < limit) begin
         @(negedge clock);
         n++;
      end
      total++;
      if (n >= limit) begin
         bad++;
         $display("[TB] FAIL %s: still waiting after %0d cycles, expected done", name, limit);
         exp_q.delete();
         exp_to_q.delete();
      end
   endtask

   // Scripted Avalon slave, acting between clock edges.
   initial begin
      int wcnt;
      int pend;
      logic [31:0] pend_data;
      wcnt = 0;
      pend = 0;
      pend_data = '0;
      forever begin
         @(posedge clock);
         #2;
         if (to_read === 1'b1) to_reads++;
         if (!slave_en) begin
            wcnt = 0;
            pend = 0;
         end else begin
            avm_waitrequest   = 1'b0;
            avm_readdatavalid = 1'b0;
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  avm_readdatavalid = 1'b1;
                  avm_readdata      = pend_data;
               end
            end else if (avm_read === 1'b1) begin
               if (wcnt < slave_wait) begin
                  avm_waitrequest = 1'b1;
                  wcnt++;
               end else begin
                  wcnt = 0;
                  reads++;
                  pend_data = avm_address ? slave_ts : slave_id;
                  if (slave_lat == 0) begin
                     avm_readdatavalid = 1'b1;
                     avm_readdata      = pend_data;
                  end else begin
                     pend = slave_lat;
                  end
               end
            end
         end
      end
   end

   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev = 1'b0;
         end else begin
            if (done && !prev) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL main.unexpected_done: got done=1 expected no result");
               end else begin
                  e = exp_q.pop_front();
                  compareResult("main", e, pass, id_mismatch, ts_mismatch, timeout, avm_read,
                                busy, captured_id, captured_ts, cyc - e.start_cyc,
                                reads - e.reads_base);
               end
            end
            prev = done;
         end
      end
   end

   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev = 1'b0;
         end else begin
            if (to_done && !prev) begin
               if (exp_to_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL to.unexpected_done: got done=1 expected no result");
               end else begin
                  e = exp_to_q.pop_front();
                  compareResult("to", e, to_pass, to_id_mm, to_ts_mm, to_timeout, to_read,
                                to_busy, to_cid, to_cts, cyc - e.start_cyc,
                                to_reads - e.reads_base);
               end
            end
            prev = to_done;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t e;
      int n;

      // Reset values, then the automatic check after reset release.
      repeat (3) @(negedge clock);
      checkResetValues("reset");
      e = mkExp(1'b1, 1'b0, 1'b0, 1'b0, GOOD_ID, GOOD_TS, 4, 2);
      e.start_cyc  = cyc;
      e.reads_base = reads;
      exp_q.push_back(e);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("auto.busy_first", busy, 1'b1);
      checkOutput("auto.read_first", avm_read, 1'b1);
      waitIdle("auto", 50);

      $display("[TB] zero-latency pass");
      applyStimulus(GOOD_ID, GOOD_TS, 0, 0, mkExp(1'b1, 1'b0, 1'b0, 1'b0, GOOD_ID, GOOD_TS, 4, 2));
      waitIdle("zero_lat", 50);

      $display("[TB] bad timestamp with retries");
      applyStimulus(GOOD_ID, BAD_TS, 0, 0, mkExp(1'b0, 1'b0, 1'b1, 1'b0, GOOD_ID, BAD_TS, 13, 8));
      waitIdle("bad_ts", 100);

      $display("[TB] waitrequest and latency, start while busy");
      applyStimulus(GOOD_ID, GOOD_TS, 3, 2, mkExp(1'b1, 1'b0, 0, 1'b0, GOOD_ID, GOOD_TS, 14, 2));
      checkOutput("restart.ts_mismatch_cleared", ts_mismatch, 1'b0);
      checkOutput("restart.busy", busy, 1'b1);
      checkOutput("restart.done", done, 1'b0);
      repeat (3) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      waitIdle("wait_lat", 100);

      $display("[TB] silent slave timeout");
      @(negedge clock);
      e = mkExp(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 23, 2);
      e.start_cyc  = cyc;
      e.reads_base = to_reads;
      exp_to_q.push_back(e);
      to_start = 1'b1;
      @(negedge clock);
      to_start = 1'b0;
      waitIdle("timeout", 100);

      $display("[TB] reset during WAIT_TS");
      applyStimulus(GOOD_ID, GOOD_TS, 0, 3, mkExp(1'b1, 1'b0, 1'b0, 1'b0, GOOD_ID, GOOD_TS, 0, 0));
      void'(exp_q.pop_back());
      n = 0;
      while (!(busy && avm_address && !avm_read) && n < 50) begin
         @(negedge clock);
         n++;
      end
      checkOutput("wait_ts.reached", (n < 50), 1'b1);
      slave_en          = 1'b0;
      avm_readdatavalid = 1'b0;
      reset             = 1'b1;
      @(negedge clock);
      checkResetValues("midreset");
      e = mkExp(1'b1, 1'b0, 1'b0, 1'b0, GOOD_ID, GOOD_TS, 4, 2);
      e.start_cyc  = cyc;
      e.reads_base = reads;
      exp_q.push_back(e);
      slave_lat         = 0;
      reset             = 1'b0;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b1;
      avm_readdata      = GOOD_TS;
      slave_en          = 1'b1;
      @(negedge clock);
      checkOutput("stray.captured_ts", captured_ts, 32'd0);
      checkOutput("stray.busy", busy, 1'b1);
      checkOutput("stray.avm_read", avm_read, 1'b1);
      waitIdle("rerun", 50);

      repeat (2) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
